// File: rtl/fp_mul_normalizer.sv
// Post-multiply normalizer: iterative normalization, round-to-nearest-even and
// IEEE-754 single packing, using a start/done handshake.
module fp_mul_normalizer #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_in,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [47:0] mant_prod,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {IDLE, LOAD, NORM, ROUND, DONE} state_t;

  state_t             state, nxt;
  logic               sgn, sticky, zero;
  logic [7:0]         ea, eb;
  logic [47:0]        m;
  logic signed [9:0]  e;

  logic               inc, ov_c, uf_c;
  logic [24:0]        rsig;
  logic signed [9:0]  e_rnd;
  logic [22:0]        frac;

  assign busy = (state != IDLE);

  // m[46] is the hidden bit once normalized; m[23] = L, m[22] = G.
  assign inc   = m[22] & (m[23] | m[21] | (|m[20:0]) | sticky);
  assign rsig  = {1'b0, m[46:23]} + 25'(inc);
  assign e_rnd = rsig[24] ? e + 10'sd1 : e;
  assign frac  = rsig[24] ? 23'd0 : rsig[22:0];
  assign ov_c  = !zero && (e_rnd >= 10'sd255);
  assign uf_c  = !zero && (e_rnd <= 10'sd0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LOAD;
      // Zero operands still pass through ROUND to keep a fixed two-step latency.
      LOAD:    nxt = (ea == 8'd0 || eb == 8'd0 || m == 48'd0) ? ROUND : NORM;
      NORM:    if (m[47] || m[46]) nxt = ROUND;
      ROUND:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result    <= 32'd0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      sgn       <= 1'b0;
      sticky    <= 1'b0;
      zero      <= 1'b0;
      ea        <= 8'd0;
      eb        <= 8'd0;
      m         <= 48'd0;
      e         <= 10'sd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sgn       <= sign_in;
          ea        <= exp_a;
          eb        <= exp_b;
          m         <= mant_prod;
          e         <= 10'({2'b00, exp_a} + {2'b00, exp_b}) - 10'(BIAS);
          sticky    <= 1'b0;
          zero      <= 1'b0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        LOAD: zero <= (ea == 8'd0 || eb == 8'd0 || m == 48'd0);
        NORM: begin
          if (m[47]) begin
            m      <= m >> 1;
            sticky <= sticky | m[0];
            e      <= e + 10'sd1;
          end else if (!m[46]) begin
            m <= m << 1;
            e <= e - 10'sd1;
          end
        end
        ROUND: begin
          done      <= 1'b1;
          overflow  <= ov_c;
          underflow <= uf_c;
          if (zero || uf_c) result <= {sgn, 31'd0};
          else if (ov_c)    result <= {sgn, 8'hFF, 23'd0};
          else              result <= {sgn, e_rnd[7:0], frac};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Randomized + directed check of fp_mul_normalizer against an arithmetic
// reference (leading-one position, integer remainder rounding).
module tb_fp_mul_normalizer;
  logic        clk = 0, rst = 0, start = 0, sign_in = 0;
  logic [7:0]  exp_a = 0, exp_b = 0;
  logic [47:0] mant_prod = 0;
  logic [31:0] result;
  logic        done, busy, overflow, underflow;
  int          checks = 0, failures = 0;

  fp_mul_normalizer #(.BIAS(127)) dut (
    .clk(clk), .rst(rst), .start(start), .sign_in(sign_in),
    .exp_a(exp_a), .exp_b(exp_b), .mant_prod(mant_prod),
    .result(result), .done(done), .busy(busy),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                input logic [47:0] mp, output logic [31:0] r,
                                output logic ov, output logic uf, output int lat);
    int p, e, sh;
    logic [63:0] sig, rem, half;
    ov = 0; uf = 0;
    if (a == 0 || b == 0 || mp == 0) begin
      r = {s, 31'b0}; lat = 2; return;
    end
    p = 0;
    for (int i = 0; i < 48; i++) if (mp[i]) p = i;
    e   = int'(a) + int'(b) - 127 + (p - 46);
    lat = 3 + ((p < 46) ? 46 - p : 0);
    if (p >= 23) begin
      sh   = p - 23;
      sig  = 64'(mp) >> sh;
      rem  = 64'(mp) & ((64'd1 << sh) - 64'd1);
      half = (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
      if (sh > 0 && (rem > half || (rem == half && sig[0]))) sig = sig + 64'd1;
    end else sig = 64'(mp) << (23 - p);
    if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; e++; end
    if (e >= 255)    begin r = {s, 8'hFF, 23'b0}; ov = 1; end
    else if (e <= 0) begin r = {s, 31'b0}; uf = 1; end
    else             r = {s, 8'(e), sig[22:0]};
  endfunction

  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [47:0] mp, input bit poke);
    logic [31:0] er;
    logic        eo, eu;
    int          el, cyc;
    logic [63:0] t;
    model(s, a, b, mp, er, eo, eu, el);
    @(negedge clk);
    sign_in = s; exp_a = a; exp_b = b; mant_prod = mp; start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (poke && cyc == 1) begin
        t = {$urandom, $urandom};
        sign_in = ~s; exp_a = 8'($urandom); exp_b = 8'($urandom); mant_prod = t[47:0]; start = 1;
      end else start = 0;
      @(posedge clk); #1 cyc++;
    end
    start = 0;
    chk("latency", 64'(cyc), 64'(el));
    chk("result", result, er);
    chk("flags", {overflow, underflow}, {eo, eu});
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    @(posedge clk); #1;
    chk("hold", {result, overflow, underflow, busy}, {er, eo, eu, 1'b0});
  endtask

  initial begin
    logic [63:0] t;
    int          dn;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {result, done, busy, overflow, underflow}, 36'd0);
    @(negedge clk) rst = 1;

    run_op(0, 127, 128, 48'h600000000000, 0);  // 1.5 x 2.0
    run_op(0, 127, 127, 48'h900000000000, 0);  // right shift
    run_op(0, 127, 127, 48'h100000000000, 0);  // two left shifts
    run_op(0, 127, 128, 48'h7FFFFFC00000, 0);  // rounding carry-out
    run_op(0, 127, 127, 48'h400000400000, 0);  // tie, L=0
    run_op(0, 127, 127, 48'h400000C00000, 0);  // tie, L=1
    run_op(1, 200, 200, 48'h400000000000, 0);  // overflow
    run_op(1, 130, 0,   48'h400000000000, 0);  // zero operand
    run_op(0, 20,  20,  48'h400000000000, 0);  // underflow
    run_op(0, 127, 127, 48'h000000000001, 0);  // max left shifts
    run_op(0, 127, 128, 48'h600000000000, 1);  // start while busy ignored

    // reset mid-normalization
    @(negedge clk);
    sign_in = 0; exp_a = 127; exp_b = 127; mant_prod = 48'h1; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    chk("reset_abort", {result, done, busy, overflow, underflow}, 36'd0);
    @(negedge clk) rst = 1;
    dn = 0;
    repeat (60) begin @(posedge clk); #1 if (done) dn++; end
    chk("no_done_after_abort", 64'(dn), 0);
    run_op(0, 127, 128, 48'h600000000000, 0);

    for (int i = 0; i < 150; i++) begin
      t = {$urandom, $urandom};
      run_op(1'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             ($urandom_range(0, 7) == 0) ? 48'd0 : (t[47:0] >> $urandom_range(0, 47)),
             $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
